// File: rtl/writeback_stage.sv
// MEM/WB pipeline boundary: registers memory-stage results, extracts and extends
// loads, flags misaligned/illegal loads, qualifies the register-file write and counts retirements.
module writeback_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValidM,
   input  logic              StallW,
   input  logic              FlushW,
   input  logic              RegWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [2:0]        LoadTypeM,
   input  logic [REG_AW-1:0] RdM,
   input  logic [XLEN-1:0]   ALU_ResultM,
   input  logic [XLEN-1:0]   ReadDataM,
   input  logic [XLEN-1:0]   PCPlus4M,
   input  logic [XLEN-1:0]   ImmExtM,
   output logic              ValidW,
   output logic              RegWriteW,
   output logic [REG_AW-1:0] RdW,
   output logic [XLEN-1:0]   ResultW,
   output logic              LoadFaultW,
   output logic [CNT_W-1:0]  RetireCount
);

   logic              vld_p0;
   logic              regwrite_p0;
   logic [1:0]        src_p0;
   logic [2:0]        ltype_p0;
   logic [REG_AW-1:0] rd_p0;
   logic [XLEN-1:0]   alu_p0;
   logic [XLEN-1:0]   rdata_p0;
   logic [XLEN-1:0]   pc4_p0;
   logic [XLEN-1:0]   imm_p0;
   logic [CNT_W-1:0]  retire_cnt;
   logic [1:0]        off_w;
   logic [XLEN-1:0]   load_data_w;

   function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      lt,
                                                    input logic [1:0]      off,
                                                    input logic [XLEN-1:0] word);
      logic signed [7:0]      b;
      logic signed [15:0]     h;
      logic signed [XLEN-1:0] ext;
      b   = word[8*off +: 8];
      h   = word[16*off[1] +: 16];
      ext = word;
      case (lt)
         3'b000:  ext = b;
         3'b100:  ext = {{(XLEN-8){1'b0}}, b};
         3'b001:  ext = h;
         3'b101:  ext = {{(XLEN-16){1'b0}}, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   // Halfwords need even offsets, words need zero offset; 011/110/111 are not RV32I loads.
   function automatic logic load_bad(input logic [2:0] lt, input logic [1:0] off);
      logic bad;
      case (lt)
         3'b001, 3'b101:         bad = off[0];
         3'b010:                 bad = (off != 2'b00);
         3'b011, 3'b110, 3'b111: bad = 1'b1;
         default:                bad = 1'b0;
      endcase
      return bad;
   endfunction

   // M -> W boundary; retirement is counted as the current WB instruction leaves.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p0      <= 1'b0;
         regwrite_p0 <= 1'b0;
         src_p0      <= '0;
         ltype_p0    <= '0;
         rd_p0       <= '0;
         alu_p0      <= '0;
         rdata_p0    <= '0;
         pc4_p0      <= '0;
         imm_p0      <= '0;
         retire_cnt  <= '0;
      end else if (!StallW) begin
         vld_p0      <= ValidM & ~FlushW;
         regwrite_p0 <= RegWriteM;
         src_p0      <= ResultSrcM;
         ltype_p0    <= LoadTypeM;
         rd_p0       <= RdM;
         alu_p0      <= ALU_ResultM;
         rdata_p0    <= ReadDataM;
         pc4_p0      <= PCPlus4M;
         imm_p0      <= ImmExtM;
         if (vld_p0 && !LoadFaultW)
            retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   assign off_w       = alu_p0[1:0];
   assign load_data_w = load_extract(ltype_p0, off_w, rdata_p0);

   always_comb begin
      ResultW = alu_p0;
      case (src_p0)
         2'b00: ResultW = alu_p0;
         2'b01: ResultW = load_data_w;
         2'b10: ResultW = pc4_p0;
         2'b11: ResultW = imm_p0;
         default: ResultW = alu_p0;
      endcase
   end

   assign LoadFaultW  = vld_p0 & (src_p0 == 2'b01) & load_bad(ltype_p0, off_w);
   assign RegWriteW   = vld_p0 & regwrite_p0 & ~LoadFaultW & (rd_p0 != '0);
   assign ValidW      = vld_p0;
   assign RdW         = rd_p0;
   assign RetireCount = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage (counter narrowed to 4 bits to reach wrap quickly).
module tb_writeback_stage;

   logic        clk, rst, ValidM, StallW, FlushW, RegWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  LoadTypeM;
   logic [4:0]  RdM;
   logic [31:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;
   logic        ValidW, RegWriteW, LoadFaultW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic [3:0]  RetireCount;

   typedef struct {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        flt;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [3:0] m_cnt;
   logic       m_v, m_f;
   int         n_total = 0;
   int         n_pass  = 0;

   writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .RdM(RdM),
      .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
      .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .LoadFaultW(LoadFaultW), .RetireCount(RetireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [1:0] off,
                                          input logic [31:0] d);
      logic [31:0] sb8, sh16;
      sb8  = d >> (off * 8);
      sh16 = off[1] ? (d >> 16) : d;
      case (lt)
         3'd0:    return {{24{sb8[7]}}, sb8[7:0]};
         3'd4:    return {24'h0, sb8[7:0]};
         3'd1:    return {{16{sh16[15]}}, sh16[15:0]};
         3'd5:    return {16'h0, sh16[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic m_fault(input logic [1:0] src, input logic [2:0] lt,
                                    input logic [1:0] off);
      if (src != 2'b01) return 1'b0;
      if (lt == 3'd3 || lt == 3'd6 || lt == 3'd7) return 1'b1;
      if (lt[1:0] == 2'b01 && off[0]) return 1'b1;
      if (lt == 3'd2 && off != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   task automatic set_in(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] alu);
      ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt; RdM = rd; ALU_ResultM = alu;
   endtask

   // Advance one edge, updating the reference model from the inputs currently driven.
   task automatic step();
      exp_t x;
      if (!rst) begin
         sb.delete(); m_cnt = '0; m_v = 1'b0; m_f = 1'b0;
      end else if (!StallW) begin
         if (m_v && !m_f) m_cnt = m_cnt + 4'd1;
         x.v   = ValidM & ~FlushW;
         x.flt = x.v & m_fault(ResultSrcM, LoadTypeM, ALU_ResultM[1:0]);
         x.rw  = x.v & RegWriteM & ~x.flt & (RdM != 5'd0);
         x.rd  = RdM;
         case (ResultSrcM)
            2'b00:   x.res = ALU_ResultM;
            2'b01:   x.res = m_load(LoadTypeM, ALU_ResultM[1:0], ReadDataM);
            2'b10:   x.res = PCPlus4M;
            default: x.res = ImmExtM;
         endcase
         sb.push_back(x);
         m_v = x.v; m_f = x.flt;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      ReadDataM = 32'h0; PCPlus4M = 32'h0; ImmExtM = 32'h0;
      set_in(1'b1, 1'b1, 2'b00, 3'd0, 5'd3, 32'h55);
      repeat (3) step();
      n_total++; if (ValidW !== 1'b0) $display("FAIL rst_valid got %b want 0", ValidW); else n_pass++;
      n_total++; if (RegWriteW !== 1'b0) $display("FAIL rst_regwrite got %b want 0", RegWriteW); else n_pass++;
      n_total++; if (RdW !== 5'd0) $display("FAIL rst_rd got %0d want 0", RdW); else n_pass++;
      n_total++; if (ResultW !== 32'h0) $display("FAIL rst_result got %h want 0", ResultW); else n_pass++;
      n_total++; if (LoadFaultW !== 1'b0) $display("FAIL rst_fault got %b want 0", LoadFaultW); else n_pass++;
      n_total++; if (RetireCount !== 4'd0) $display("FAIL rst_count got %0d want 0", RetireCount); else n_pass++;
      rst = 1'b1;
      step(); e = sb.pop_front();
      n_total++; if (ValidW !== 1'b1) $display("FAIL post_rst_valid got %b want 1", ValidW); else n_pass++;
      n_total++; if (ResultW !== e.res) $display("FAIL post_rst_result got %h want %h", ResultW, e.res); else n_pass++;
      n_total++; if (RetireCount !== 4'd0) $display("FAIL post_rst_count got %0d want 0", RetireCount); else n_pass++;
      step(); e = sb.pop_front();
      n_total++; if (RetireCount !== 4'd1) $display("FAIL first_retire got %0d want 1", RetireCount); else n_pass++;
   endtask

   task automatic test_load_ext();
      logic [2:0]  lt_t[5]   = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [1:0]  off_t[5]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [31:0] want_t[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
      ReadDataM = 32'h80FF7F01;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, 2'b01, lt_t[i], 5'd10, {30'h400, off_t[i]});
         step(); e = sb.pop_front();
         n_total++; if (ResultW !== want_t[i]) $display("FAIL load_%0d ResultW got %h want %h", i, ResultW, want_t[i]); else n_pass++;
         n_total++; if (RegWriteW !== e.rw || LoadFaultW !== e.flt) $display("FAIL load_%0d we/fault got %b%b want %b%b", i, RegWriteW, LoadFaultW, e.rw, e.flt); else n_pass++;
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  lt_t[3] = '{3'd2, 3'd1, 3'd3};
      logic [31:0] ad_t[3] = '{32'h1002, 32'h1001, 32'h1000};
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b1, 2'b01, lt_t[i], 5'd5, ad_t[i]);
         step(); e = sb.pop_front();
         n_total++; if (LoadFaultW !== 1'b1) $display("FAIL misalign_%0d fault got %b want 1", i, LoadFaultW); else n_pass++;
         n_total++; if (RegWriteW !== 1'b0) $display("FAIL misalign_%0d regwrite got %b want 0", i, RegWriteW); else n_pass++;
         n_total++; if (RetireCount !== m_cnt) $display("FAIL misalign_%0d count got %0d want %0d", i, RetireCount, m_cnt); else n_pass++;
      end
      set_in(1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 32'h0);
      step(); e = sb.pop_front();
      n_total++; if (RetireCount !== m_cnt) $display("FAIL misalign_drain count got %0d want %0d", RetireCount, m_cnt); else n_pass++;
   endtask

   task automatic test_mux_x0();
      PCPlus4M = 32'h104; ImmExtM = 32'hFFFFF800;
      set_in(1'b1, 1'b1, 2'b10, 3'd0, 5'd1, 32'h0);
      step(); e = sb.pop_front();
      n_total++; if (ResultW !== 32'h104) $display("FAIL mux_pc4 got %h want 00000104", ResultW); else n_pass++;
      set_in(1'b1, 1'b1, 2'b11, 3'd0, 5'd2, 32'h0);
      step(); e = sb.pop_front();
      n_total++; if (ResultW !== e.res) $display("FAIL mux_imm got %h want %h", ResultW, e.res); else n_pass++;
      n_total++; if (RdW !== e.rd) $display("FAIL mux_rd got %0d want %0d", RdW, e.rd); else n_pass++;
      set_in(1'b1, 1'b1, 2'b00, 3'd0, 5'd0, 32'hDEAD);
      step(); e = sb.pop_front();
      n_total++; if (RegWriteW !== 1'b0 || ValidW !== 1'b1) $display("FAIL x0 we/valid got %b%b want 01", RegWriteW, ValidW); else n_pass++;
      set_in(1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 32'h0);
      step(); e = sb.pop_front();
      n_total++; if (RetireCount !== m_cnt) $display("FAIL x0_counted got %0d want %0d", RetireCount, m_cnt); else n_pass++;
   endtask

   task automatic test_stall_flush();
      exp_t held;
      set_in(1'b1, 1'b1, 2'b00, 3'd0, 5'd7, 32'hAAAA);
      step(); held = sb.pop_front();
      StallW = 1'b1; FlushW = 1'b1;
      set_in(1'b1, 1'b1, 2'b00, 3'd0, 5'd9, 32'hBBBB);
      for (int i = 0; i < 4; i++) begin
         step();
         n_total++; if (ValidW !== 1'b1 || ResultW !== held.res || RdW !== held.rd) $display("FAIL stall_%0d hold got %b %h %0d want 1 %h %0d", i, ValidW, ResultW, RdW, held.res, held.rd); else n_pass++;
         n_total++; if (RetireCount !== m_cnt) $display("FAIL stall_%0d count got %0d want %0d", i, RetireCount, m_cnt); else n_pass++;
      end
      StallW = 1'b0; FlushW = 1'b0;
      step(); e = sb.pop_front();
      n_total++; if (RetireCount !== m_cnt || ResultW !== 32'hBBBB) $display("FAIL stall_release got %0d %h want %0d 0000bbbb", RetireCount, ResultW, m_cnt); else n_pass++;
      FlushW = 1'b1;
      step(); e = sb.pop_front();
      n_total++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) $display("FAIL flush valid/we got %b%b want 00", ValidW, RegWriteW); else n_pass++;
      FlushW = 1'b0;
      step(); e = sb.pop_front();
      n_total++; if (RetireCount !== m_cnt) $display("FAIL flush_uncounted got %0d want %0d", RetireCount, m_cnt); else n_pass++;
      // Reset while stalled discards the held instruction.
      StallW = 1'b1; rst = 1'b0;
      step();
      n_total++; if (ValidW !== 1'b0 || RetireCount !== 4'd0) $display("FAIL rst_in_stall got %b %0d want 0 0", ValidW, RetireCount); else n_pass++;
      rst = 1'b1; StallW = 1'b0;
   endtask

   task automatic test_wrap();
      logic [3:0] want;
      rst = 1'b0; step(); rst = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         set_in(i <= 17, 1'b1, 2'b00, 3'd0, 5'd4, 32'(i));
         step(); e = sb.pop_front();
         want = 4'((i - 1) % 16);
         n_total++; if (RetireCount !== want) $display("FAIL wrap_%0d count got %0d want %0d", i, RetireCount, want); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_load_ext();
      test_misaligned();
      test_mux_x0();
      test_stall_flush();
      test_wrap();
      n_total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d want 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised writeback stage for the 5-stage RISC-V pipeline. It replaces the two-way ALU/memory result select with a registered MEM/WB pipeline boundary that has valid, stall and flush control. It also adds a four-way result select, RV32I load alignment and sign/zero extension, misaligned-load detection, x0 write suppression, and a retired-instruction counter. It sits between the memory cycle and the register file, and drives the register-file write port and the forwarding unit.

## Interface
- XLEN, 32, datapath width (32 only for load extraction; ALU/PC/imm paths are XLEN wide)
- REG_AW, 5, register address width
- CNT_W, 64, retire counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- ValidM  in  1  memory-stage instruction valid
- StallW  in  1  hold the WB register and counter
- FlushW  in  1  kill the instruction entering WB
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
- LoadTypeM  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- RdM  in  REG_AW  destination register
- ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM  in  XLEN  result candidates; ReadDataM is the aligned memory word
- ValidW  out  1  WB holds a live instruction
- RegWriteW  out  1  qualified register-file write enable
- RdW  out  REG_AW  write address
- ResultW  out  XLEN  write data and forwarding value
- LoadFaultW  out  1  WB instruction is a misaligned or illegal load
- RetireCount  out  CNT_W  retired-instruction count

## Operation
- Capture: on each edge with rst=1 and StallW=0, the WB register loads all M-side fields. The stored valid is ValidM & ~FlushW.
- Hold: StallW=1 holds every WB register and RetireCount. FlushW is ignored while StallW=1, because no capture occurs.
- Result mux: ResultW is a combinational function of the WB register. 00 selects ALU_ResultW, 01 selects LoadDataW, 10 selects PCPlus4W, 11 selects ImmExtW.
- Load extraction uses off = ALU_ResultW[1:0].
  - LB/LBU select byte ReadDataW[8*off+7 : 8*off], then sign- or zero-extend it.
  - LH/LHU select halfword ReadDataW[16*off[1]+15 : 16*off[1]], then sign- or zero-extend it.
  - LW passes the word through unchanged.
- Fault: LoadFaultW = ValidW & (ResultSrcW==01) & (any of the following):
  - LH/LHU with off[0]=1
  - LW with off≠0
  - LoadTypeW equal to 011, 110 or 111
- Write qualify: RegWriteW = ValidW & RegWriteR & ~LoadFaultW & (RdW≠0). RegWriteR is the captured RegWriteM.
- Retire counting: RetireCount increments by 1 on each edge where all of the following hold:
  - rst=1
  - StallW=0
  - ValidW=1
  - LoadFaultW=0
- The retire count therefore advances when an instruction leaves WB, not when it enters, and a stalled instruction is counted once.
- Counter wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Latency: 1 cycle from M inputs to W outputs. ResultW, RegWriteW and LoadFaultW are valid in the same cycle as ValidW.
- Reset (rst=0 at an edge) clears all WB registers and RetireCount to 0. After reset: ValidW=0, RegWriteW=0, RdW=0, ResultW=0, LoadFaultW=0, RetireCount=0.
- Reset has priority over StallW and FlushW. Reset asserted mid-stall discards the held instruction without counting it.
- Back-to-back valid instructions with StallW=0 retire one per cycle.
- An instruction captured with FlushW=1 appears in WB with ValidW=0. Its RegWriteW, LoadFaultW and count contribution are all 0, although its data fields are still loaded.
- The first edge with rst=1 already performs a normal capture.

## Test plan
- Reset: hold rst=0 for 3 edges with ValidM=1 and RegWriteM=1 -> all outputs 0. Release rst -> one edge later ValidW=1, and RetireCount=0 until the next edge.
- Load extension: ReadDataM=0x80FF7F01.
  - LB at off 3 -> ResultW=0xFFFFFF80.
  - LBU at off 1 -> 0x0000007F.
  - LH at off 2 -> 0xFFFF80FF.
  - LHU at off 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Misaligned: LW at address 0x1002, RegWriteM=1, Rd=5 -> LoadFaultW=1, RegWriteW=0, RetireCount unchanged. LH at 0x1001 gives the same response. LoadType 011 with off 0 -> LoadFaultW=1.
- Mux and x0:
  - Src 10 with PCPlus4M=0x104 -> ResultW=0x104.
  - Src 11 with ImmExtM=0xFFFFF800 -> ResultW=0xFFFFF800.
  - Rd=0 with RegWriteM=1 -> RegWriteW=0 and ValidW=1, and the instruction is counted.
- Stall/flush: valid instruction A in WB, then StallW=1 for 4 cycles with FlushW=1 -> A is held, RetireCount is unchanged until release and then increments by exactly 1. Afterwards, FlushW=1 with StallW=0 and ValidM=1 -> ValidW=0 next cycle.
- Counter wrap (CNT_W=4): retire 17 valid instructions -> RetireCount reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
